roce_tx_opcode_segmenter: RTL and testbench
===========================================

# roce_tx_opcode_segmenter

Splits one RDMA work request (RC SEND or RDMA WRITE) into a sequence of per-packet BTH/RETH/ImmDt header descriptors. Each descriptor carries the correct RC opcode (FIRST/MIDDLE/LAST/ONLY, with or without immediate), the PSN and the payload length. Sits between the QP work-request source and the RoCE header builder, and uses the team's RoCE opcode constants. One descriptor corresponds to one outgoing packet; the payload datapath consumes `m_hdr_payload_length` bytes per descriptor.

## Interface
Parameters:
- LEN_W, 32, width of work-request byte length.
- PSN_W, 24, PSN width; PSN arithmetic is modulo 2^PSN_W.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  reset, synchronous, active-high.
- s_wr_valid / s_wr_ready  in/out  1  work-request handshake.
- s_wr_is_send  in  1  1 = SEND opcodes, 0 = RDMA WRITE opcodes.
- s_wr_length  in  LEN_W  total payload bytes; 0 is legal.
- s_wr_remote_addr  in  64  RETH virtual address.
- s_wr_rkey  in  32  RETH R_Key.
- s_wr_dest_qpn  in  24  destination QPN.
- s_wr_imm_valid  in  1  request carries immediate data.
- s_wr_immediate  in  32  immediate data.
- cfg_pmtu  in  3  PMTU code: 0=256, 1=512, 2=1024, 3=2048, 4..7=4096.
- cfg_start_psn  in  PSN_W  PSN load value.
- cfg_psn_load  in  1  load `cfg_start_psn` into the PSN counter.
- m_hdr_valid / m_hdr_ready  out/in  1  descriptor handshake.
- m_hdr_opcode  out  8  BTH opcode.
- m_hdr_psn  out  PSN_W  packet PSN.
- m_hdr_dest_qpn  out  24  destination QPN.
- m_hdr_ack_req  out  1  BTH AckReq bit.
- m_hdr_reth_valid  out  1  RETH present.
- m_hdr_reth_vaddr  out  64  RETH virtual address.
- m_hdr_reth_rkey  out  32  RETH R_Key.
- m_hdr_reth_length  out  32  RETH DMA length.
- m_hdr_immdt_valid  out  1  ImmDt present.
- m_hdr_immdt  out  32  ImmDt value.
- m_hdr_payload_length  out  16  payload bytes in this packet.
- busy  out  1  high while a work request is being segmented.
- psn_next  out  PSN_W  PSN to be assigned to the next packet.

## Operation
- States: IDLE and EMIT.
- IDLE:
  - `s_wr_ready` = 1.
  - On `s_wr_valid`: capture all request fields; latch PMTU, decoded once and held for the whole request; set `remaining` = length; go to EMIT.
- Packet computation:
  - `pkt_len` = min(remaining, PMTU).
  - The current packet is the first packet when nothing of the request has been sent yet.
  - The current packet is the last packet when remaining ≤ PMTU. This includes remaining = 0.
- Opcode selection:
  - first and last: ONLY (0x04 SEND, 0x0A WRITE); with an immediate, ONLY_IMD (0x05 / 0x0B).
  - first, not last: FIRST (0x00 / 0x06).
  - neither first nor last: MIDDLE (0x01 / 0x07).
  - last, not first: LAST (0x02 / 0x08); with an immediate, LAST_IMD (0x03 / 0x09).
- RETH: present only on WRITE FIRST/ONLY. `vaddr` = original address, `rkey` = R_Key, `length` = total request length. SEND never carries a RETH.
- ImmDt: present only on LAST_IMD/ONLY_IMD.
- `m_hdr_ack_req` = 1 on LAST/ONLY variants only.
- PSN:
  - Each descriptor takes `psn_next`.
  - `psn_next` increments by 1 on every descriptor handshake, modulo 2^PSN_W (0xFFFFFF → 0x000000).
- EMIT: on each descriptor handshake, remaining -= pkt_len. After the last packet's handshake, go to IDLE.
- `cfg_psn_load`: honoured in IDLE only, and is ignored in EMIT. If asserted in the same cycle as a work-request acceptance, the loaded PSN applies to that request's first packet.
- `busy` = (state == EMIT).
- Width rules:
  - remaining is LEN_W wide.
  - `pkt_len` ≤ 4096, zero-extended to 16 bits.
  - No overflow is possible.

## Timing
- Reset values:
  - state IDLE; `s_wr_ready` 1 once `rst` deasserts; `s_wr_ready` 0 while `rst` is high.
  - `m_hdr_valid` 0, `busy` 0, `psn_next` 0.
  - All descriptor fields 0.
- Latency: request accepted in cycle N → first `m_hdr_valid` in N+1.
- Outputs are registered.
- With `m_hdr_ready` held high, one descriptor is emitted per cycle.
- After the final handshake in cycle M, `s_wr_ready` = 1 in cycle M+1. This gives one bubble between requests.
- Backpressure: while `m_hdr_valid` && !`m_hdr_ready`, all `m_hdr_*` outputs are held stable. `valid` never drops without a handshake.
- `s_wr_ready` = 0 throughout EMIT.
- `rst` mid-request: the request is abandoned and all outputs take their reset values in the next cycle. The PSN counter returns to 0.

## Test plan
- WRITE, length 0, PSN 5, no imm:
  - Expect one descriptor: opcode 0x0A, psn 5, payload 0, `reth_length` 0, `ack_req` 1.
- WRITE, length 1000, pmtu code 0, addr 0x1000, PSN 0:
  - Opcodes 0x06, 0x07, 0x07, 0x08.
  - Payloads 256, 256, 256, 232; PSNs 0..3.
  - RETH on first packet only, `reth_length` 1000.
  - `ack_req` only on the last packet.
- SEND with imm 0xDEADBEEF, length 4096, pmtu code 4:
  - One descriptor: 0x05, payload 4096, ImmDt 0xDEADBEEF, no RETH.
- PSN load 0xFFFFFE, SEND length 600, pmtu code 0:
  - PSNs 0xFFFFFE, 0xFFFFFF, 0x000000; opcodes 0x00, 0x01, 0x02.
  - `psn_next` = 1 afterwards.
- Random `m_hdr_ready` throttling, WRITE length 5000, pmtu code 1:
  - 10 descriptors; fields stable while stalled.
  - Total payload = 5000.
  - `s_wr_ready` low until one cycle after the last handshake.
- `rst` pulsed during the 2nd packet of a 4-packet request:
  - Next cycle: `m_hdr_valid` 0, `busy` 0, `psn_next` 0.
  - A new request then starts with an ONLY/FIRST opcode at PSN 0.

Source files
------------

// File: rtl/roce_tx_opcode_segmenter.sv
// Segments one RC SEND / RDMA WRITE work request into per-packet BTH/RETH/ImmDt
// header descriptors with RC opcode, PSN and payload length.
module roce_tx_opcode_segmenter #(
  parameter int LEN_W = 32,
  parameter int PSN_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_wr_valid,
  output logic             s_wr_ready,
  input  logic             s_wr_is_send,
  input  logic [LEN_W-1:0] s_wr_length,
  input  logic [63:0]      s_wr_remote_addr,
  input  logic [31:0]      s_wr_rkey,
  input  logic [23:0]      s_wr_dest_qpn,
  input  logic             s_wr_imm_valid,
  input  logic [31:0]      s_wr_immediate,
  input  logic [2:0]       cfg_pmtu,
  input  logic [PSN_W-1:0] cfg_start_psn,
  input  logic             cfg_psn_load,
  output logic             m_hdr_valid,
  input  logic             m_hdr_ready,
  output logic [7:0]       m_hdr_opcode,
  output logic [PSN_W-1:0] m_hdr_psn,
  output logic [23:0]      m_hdr_dest_qpn,
  output logic             m_hdr_ack_req,
  output logic             m_hdr_reth_valid,
  output logic [63:0]      m_hdr_reth_vaddr,
  output logic [31:0]      m_hdr_reth_rkey,
  output logic [31:0]      m_hdr_reth_length,
  output logic             m_hdr_immdt_valid,
  output logic [31:0]      m_hdr_immdt,
  output logic [15:0]      m_hdr_payload_length,
  output logic             busy,
  output logic [PSN_W-1:0] psn_next
);

  localparam logic [7:0] SEND_FIRST = 8'h00, SEND_MIDDLE = 8'h01, SEND_LAST = 8'h02;
  localparam logic [7:0] SEND_LAST_IMD = 8'h03, SEND_ONLY = 8'h04, SEND_ONLY_IMD = 8'h05;
  localparam logic [7:0] WR_FIRST = 8'h06, WR_MIDDLE = 8'h07, WR_LAST = 8'h08;
  localparam logic [7:0] WR_LAST_IMD = 8'h09, WR_ONLY = 8'h0A, WR_ONLY_IMD = 8'h0B;

  typedef enum logic {IDLE, EMIT} state_t;

  function automatic logic [12:0] pmtu_bytes(input logic [2:0] code);
    case (code)
      3'd0:    return 13'd256;
      3'd1:    return 13'd512;
      3'd2:    return 13'd1024;
      3'd3:    return 13'd2048;
      default: return 13'd4096;
    endcase
  endfunction

  function automatic logic [7:0] opcode_sel(input logic is_send, input logic first,
                                            input logic last, input logic imm);
    logic [7:0] op;
    if (first && last)
      op = is_send ? (imm ? SEND_ONLY_IMD : SEND_ONLY) : (imm ? WR_ONLY_IMD : WR_ONLY);
    else if (first)
      op = is_send ? SEND_FIRST : WR_FIRST;
    else if (!last)
      op = is_send ? SEND_MIDDLE : WR_MIDDLE;
    else
      op = is_send ? (imm ? SEND_LAST_IMD : SEND_LAST) : (imm ? WR_LAST_IMD : WR_LAST);
    return op;
  endfunction

  state_t             r_state, w_state_nxt;
  logic [LEN_W-1:0]   r_rem;
  logic               r_last;
  logic               r_is_send;
  logic               r_imm_valid;
  logic [31:0]        r_imm;
  logic [12:0]        r_pmtu;
  logic [PSN_W-1:0]   r_psn;

  logic               w_idle, w_accept, w_hs, w_load;
  logic [LEN_W-1:0]   w_rem;
  logic [12:0]        w_pmtu, w_pkt;
  logic               w_last, w_send, w_imm_v;
  logic [31:0]        w_imm;
  logic [PSN_W-1:0]   w_psn;

  assign w_idle      = (r_state == IDLE);
  assign s_wr_ready  = w_idle && !rst;
  assign w_accept    = w_idle && s_wr_valid;
  assign w_hs        = (r_state == EMIT) && m_hdr_ready;
  assign m_hdr_valid = (r_state == EMIT);
  assign busy        = (r_state == EMIT);
  assign psn_next    = r_psn;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      IDLE: if (s_wr_valid) begin
        w_state_nxt = EMIT;
        w_load      = 1'b1;
      end
      EMIT: if (m_hdr_ready) begin
        if (r_last) w_state_nxt = IDLE;
        else        w_load      = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // The descriptor for the next packet is computed from the request inputs when
  // accepting, otherwise from the bytes left after the packet now on the bus.
  always_comb begin
    w_rem   = w_idle ? s_wr_length : r_rem;
    w_pmtu  = w_idle ? pmtu_bytes(cfg_pmtu) : r_pmtu;
    w_send  = w_idle ? s_wr_is_send : r_is_send;
    w_imm_v = w_idle ? s_wr_imm_valid : r_imm_valid;
    w_imm   = w_idle ? s_wr_immediate : r_imm;
    w_last  = (w_rem <= LEN_W'(w_pmtu));
    w_pkt   = w_last ? w_rem[12:0] : w_pmtu;
    if (w_idle) w_psn = cfg_psn_load ? cfg_start_psn : r_psn;
    else        w_psn = r_psn + PSN_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Descriptor register stage: loads on acceptance and on each non-final handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem <= '0; r_last <= 1'b0; r_is_send <= 1'b0; r_imm_valid <= 1'b0;
      r_imm <= '0; r_pmtu <= '0; r_psn <= '0;
      m_hdr_opcode <= '0; m_hdr_psn <= '0; m_hdr_dest_qpn <= '0; m_hdr_ack_req <= 1'b0;
      m_hdr_reth_valid <= 1'b0; m_hdr_reth_vaddr <= '0; m_hdr_reth_rkey <= '0;
      m_hdr_reth_length <= '0; m_hdr_immdt_valid <= 1'b0; m_hdr_immdt <= '0;
      m_hdr_payload_length <= '0;
    end else begin
      if (w_idle && !w_accept && cfg_psn_load) r_psn <= cfg_start_psn;
      if (w_accept) begin
        r_psn          <= w_psn;
        r_is_send      <= s_wr_is_send;
        r_imm_valid    <= s_wr_imm_valid;
        r_imm          <= s_wr_immediate;
        r_pmtu         <= w_pmtu;
        m_hdr_dest_qpn <= s_wr_dest_qpn;
      end else if (w_hs) begin
        r_psn <= r_psn + PSN_W'(1);
      end
      if (w_load) begin
        r_rem                <= w_rem - LEN_W'(w_pkt);
        r_last               <= w_last;
        m_hdr_opcode         <= opcode_sel(w_send, w_idle, w_last, w_imm_v);
        m_hdr_psn            <= w_psn;
        m_hdr_ack_req        <= w_last;
        m_hdr_reth_valid     <= w_idle && !w_send;
        m_hdr_reth_vaddr     <= (w_idle && !w_send) ? s_wr_remote_addr : 64'd0;
        m_hdr_reth_rkey      <= (w_idle && !w_send) ? s_wr_rkey : 32'd0;
        m_hdr_reth_length    <= (w_idle && !w_send) ? 32'(s_wr_length) : 32'd0;
        m_hdr_immdt_valid    <= w_last && w_imm_v;
        m_hdr_immdt          <= (w_last && w_imm_v) ? w_imm : 32'd0;
        m_hdr_payload_length <= {3'b000, w_pkt};
      end
    end
  end

endmodule

// File: tb/tb_roce_tx_opcode_segmenter.sv
// Directed bench for roce_tx_opcode_segmenter: hand-computed descriptor sequences,
// PSN wrap, backpressure stability and mid-request reset.
module tb_roce_tx_opcode_segmenter;
  logic        clk = 1'b0;
  logic        rst;
  logic        s_wr_valid, s_wr_ready, s_wr_is_send, s_wr_imm_valid;
  logic [31:0] s_wr_length, s_wr_rkey, s_wr_immediate;
  logic [63:0] s_wr_remote_addr;
  logic [23:0] s_wr_dest_qpn;
  logic [2:0]  cfg_pmtu;
  logic [23:0] cfg_start_psn;
  logic        cfg_psn_load;
  logic        m_hdr_valid, m_hdr_ready, m_hdr_ack_req, m_hdr_reth_valid, m_hdr_immdt_valid;
  logic [7:0]  m_hdr_opcode;
  logic [23:0] m_hdr_psn, m_hdr_dest_qpn, psn_next;
  logic [63:0] m_hdr_reth_vaddr;
  logic [31:0] m_hdr_reth_rkey, m_hdr_reth_length, m_hdr_immdt;
  logic [15:0] m_hdr_payload_length;
  logic        busy;

  roce_tx_opcode_segmenter dut (
    .clk(clk), .rst(rst),
    .s_wr_valid(s_wr_valid), .s_wr_ready(s_wr_ready), .s_wr_is_send(s_wr_is_send),
    .s_wr_length(s_wr_length), .s_wr_remote_addr(s_wr_remote_addr), .s_wr_rkey(s_wr_rkey),
    .s_wr_dest_qpn(s_wr_dest_qpn), .s_wr_imm_valid(s_wr_imm_valid),
    .s_wr_immediate(s_wr_immediate), .cfg_pmtu(cfg_pmtu), .cfg_start_psn(cfg_start_psn),
    .cfg_psn_load(cfg_psn_load), .m_hdr_valid(m_hdr_valid), .m_hdr_ready(m_hdr_ready),
    .m_hdr_opcode(m_hdr_opcode), .m_hdr_psn(m_hdr_psn), .m_hdr_dest_qpn(m_hdr_dest_qpn),
    .m_hdr_ack_req(m_hdr_ack_req), .m_hdr_reth_valid(m_hdr_reth_valid),
    .m_hdr_reth_vaddr(m_hdr_reth_vaddr), .m_hdr_reth_rkey(m_hdr_reth_rkey),
    .m_hdr_reth_length(m_hdr_reth_length), .m_hdr_immdt_valid(m_hdr_immdt_valid),
    .m_hdr_immdt(m_hdr_immdt), .m_hdr_payload_length(m_hdr_payload_length),
    .busy(busy), .psn_next(psn_next)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  g_opc  [0:15];
  logic [23:0] g_psn  [0:15];
  int          g_pay  [0:15];
  logic        g_rv   [0:15];
  logic [31:0] g_rlen [0:15];
  logic [63:0] g_va   [0:15];
  logic        g_ack  [0:15];
  logic        g_iv   [0:15];
  logic [31:0] g_imm  [0:15];
  logic [23:0] g_qpn;
  int          got_n;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_wr(input bit is_send, input int len, input logic [63:0] addr,
                         input bit immv, input logic [31:0] imm, input logic [2:0] pmtu,
                         input bit ld, input logic [23:0] start);
    int w = 0;
    while (!s_wr_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    chk("wr_ready_wait", s_wr_ready, 1);
    s_wr_is_send = is_send; s_wr_length = len; s_wr_remote_addr = addr;
    s_wr_rkey = 32'hCAFE0001; s_wr_dest_qpn = 24'h123456;
    s_wr_imm_valid = immv; s_wr_immediate = imm; cfg_pmtu = pmtu;
    cfg_psn_load = ld; cfg_start_psn = start;
    s_wr_valid = 1'b1;
    @(posedge clk); #1;
    s_wr_valid = 1'b0; cfg_psn_load = 1'b0;
    chk("lat_valid", m_hdr_valid, 1);
  endtask

  task automatic collect(input int n, input bit thr, input int ld_cyc);
    int cyc = 0;
    bit stalled = 0;
    logic [7:0]  s_opc;
    logic [23:0] s_psn;
    logic [15:0] s_pay;
    got_n = 0;
    while (got_n < n && cyc < 400) begin
      if (cyc >= ld_cyc) cfg_psn_load = 1'b0;
      m_hdr_ready = thr ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (stalled) begin
        chk("stall_vld", m_hdr_valid, 1);
        chk("stall_opc", m_hdr_opcode, s_opc);
        chk("stall_psn", m_hdr_psn, s_psn);
        chk("stall_pay", m_hdr_payload_length, s_pay);
      end
      stalled = 0;
      if (m_hdr_valid) begin
        chk("rdy_low", s_wr_ready, 0);
        if (m_hdr_ready) begin
          g_opc[got_n] = m_hdr_opcode;   g_psn[got_n] = m_hdr_psn;
          g_pay[got_n] = int'(m_hdr_payload_length);
          g_rv[got_n]  = m_hdr_reth_valid; g_rlen[got_n] = m_hdr_reth_length;
          g_va[got_n]  = m_hdr_reth_vaddr; g_ack[got_n]  = m_hdr_ack_req;
          g_iv[got_n]  = m_hdr_immdt_valid; g_imm[got_n] = m_hdr_immdt;
          if (got_n == 0) g_qpn = m_hdr_dest_qpn;
          got_n++;
        end else begin
          stalled = 1;
          s_opc = m_hdr_opcode; s_psn = m_hdr_psn; s_pay = m_hdr_payload_length;
        end
      end
      @(posedge clk); #1; cyc++;
    end
    cfg_psn_load = 1'b0;
    m_hdr_ready  = 1'b1;
    chk("ndesc", got_n, n);
    chk("rdy_after", s_wr_ready, 1);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    logic [7:0] exp_op5;
    int total;
    rst = 1'b1; s_wr_valid = 1'b0; s_wr_is_send = 1'b0; s_wr_length = '0;
    s_wr_remote_addr = '0; s_wr_rkey = '0; s_wr_dest_qpn = '0; s_wr_imm_valid = 1'b0;
    s_wr_immediate = '0; cfg_pmtu = '0; cfg_start_psn = '0; cfg_psn_load = 1'b0;
    m_hdr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_ready", s_wr_ready, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_wr_ready_rel", s_wr_ready, 1);
    chk("rst_valid", m_hdr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_psn_next", psn_next, 0);
    chk("rst_opcode", m_hdr_opcode, 0);
    chk("rst_payload", m_hdr_payload_length, 0);

    // WRITE length 0, PSN loaded to 5 together with the request
    send_wr(1'b0, 0, 64'h2000, 1'b0, 32'h0, 3'd0, 1'b1, 24'd5);
    collect(1, 1'b0, 0);
    chk("t1_opc", g_opc[0], 8'h0A);
    chk("t1_psn", g_psn[0], 24'd5);
    chk("t1_pay", g_pay[0], 0);
    chk("t1_rv", g_rv[0], 1);
    chk("t1_rlen", g_rlen[0], 0);
    chk("t1_ack", g_ack[0], 1);
    chk("t1_qpn", g_qpn, 24'h123456);
    chk("t1_psn_next", psn_next, 24'd6);

    // PSN load while idle, then WRITE 1000 at PMTU 256
    cfg_start_psn = 24'd0; cfg_psn_load = 1'b1;
    @(posedge clk); #1;
    cfg_psn_load = 1'b0;
    chk("t2_load", psn_next, 24'd0);
    send_wr(1'b0, 1000, 64'h1000, 1'b0, 32'h0, 3'd0, 1'b0, 24'd0);
    collect(4, 1'b0, 0);
    chk("t2_opc0", g_opc[0], 8'h06); chk("t2_opc1", g_opc[1], 8'h07);
    chk("t2_opc2", g_opc[2], 8'h07); chk("t2_opc3", g_opc[3], 8'h08);
    chk("t2_pay0", g_pay[0], 256); chk("t2_pay1", g_pay[1], 256);
    chk("t2_pay2", g_pay[2], 256); chk("t2_pay3", g_pay[3], 232);
    for (int i = 0; i < 4; i++) begin
      chk("t2_psn", g_psn[i], 24'(i));
      chk("t2_rv", g_rv[i], (i == 0));
      chk("t2_ack", g_ack[i], (i == 3));
      chk("t2_iv", g_iv[i], 0);
    end
    chk("t2_rlen", g_rlen[0], 32'd1000);
    chk("t2_va", g_va[0], 64'h1000);

    // SEND with immediate, exactly one 4096-byte packet
    send_wr(1'b1, 4096, 64'h0, 1'b1, 32'hDEADBEEF, 3'd4, 1'b0, 24'd0);
    collect(1, 1'b0, 0);
    chk("t3_opc", g_opc[0], 8'h05);
    chk("t3_pay", g_pay[0], 4096);
    chk("t3_iv", g_iv[0], 1);
    chk("t3_imm", g_imm[0], 32'hDEADBEEF);
    chk("t3_rv", g_rv[0], 0);
    chk("t3_psn", g_psn[0], 24'd4);

    // PSN wrap across a 3-packet SEND
    send_wr(1'b1, 600, 64'h0, 1'b0, 32'h0, 3'd0, 1'b1, 24'hFFFFFE);
    collect(3, 1'b0, 0);
    chk("t4_psn0", g_psn[0], 24'hFFFFFE); chk("t4_psn1", g_psn[1], 24'hFFFFFF);
    chk("t4_psn2", g_psn[2], 24'h000000);
    chk("t4_opc0", g_opc[0], 8'h00); chk("t4_opc1", g_opc[1], 8'h01);
    chk("t4_opc2", g_opc[2], 8'h02);
    chk("t4_pay2", g_pay[2], 88);
    chk("t4_psn_next", psn_next, 24'd1);

    // Throttled WRITE 5000 at PMTU 512; a PSN load held during EMIT must be ignored
    send_wr(1'b0, 5000, 64'h8000, 1'b0, 32'h0, 3'd1, 1'b0, 24'd0);
    cfg_start_psn = 24'h000123; cfg_psn_load = 1'b1;
    collect(10, 1'b1, 4);
    total = 0;
    for (int i = 0; i < 10; i++) begin
      exp_op5 = (i == 0) ? 8'h06 : ((i == 9) ? 8'h08 : 8'h07);
      chk("t5_opc", g_opc[i], exp_op5);
      chk("t5_psn", g_psn[i], 24'(i + 1));
      total += g_pay[i];
    end
    chk("t5_pay9", g_pay[9], 392);
    chk("t5_total", total, 5000);
    chk("t5_psn_next", psn_next, 24'd11);

    // Reset while the 2nd packet of a 4-packet WRITE is presented
    send_wr(1'b0, 1000, 64'h4000, 1'b0, 32'h0, 3'd0, 1'b0, 24'd0);
    @(posedge clk); #1;
    chk("t6_opc_pkt2", m_hdr_opcode, 8'h07);
    chk("t6_psn_pkt2", m_hdr_psn, 24'd12);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_valid", m_hdr_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_psn_next", psn_next, 0);
    chk("t6_opc_rst", m_hdr_opcode, 0);
    rst = 1'b0;
    send_wr(1'b1, 100, 64'h0, 1'b0, 32'h0, 3'd0, 1'b0, 24'd0);
    collect(1, 1'b0, 0);
    chk("t6_new_opc", g_opc[0], 8'h04);
    chk("t6_new_psn", g_psn[0], 24'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
